// File: rtl/fmac_norm_shift.sv
// FMAC normalization stage: left-shifts the adder sum by the LZA count, fixes the
// one-short underestimate and adjusts the exponent. Optional Err_SO via FMAC_NORM_ERRCHK_EN.
module fmac_norm_shift #(
    parameter int C_WIDTH     = 74,
    parameter int C_LZ_WIDTH  = 7,
    parameter int C_EXP_WIDTH = 10
) (
    input  logic                   Clk_CI,
    input  logic                   Rst_RBI,
    input  logic                   Valid_SI,
    output logic                   Ready_SO,
    input  logic [C_WIDTH-1:0]     Sum_DI,
    input  logic [C_LZ_WIDTH-1:0]  Lead_DI,
    input  logic                   No_one_SI,
    input  logic [C_EXP_WIDTH-1:0] Exp_DI,
    output logic                   Valid_SO,
    input  logic                   Ready_SI,
    output logic [C_WIDTH-1:0]     Mant_DO,
    output logic [C_EXP_WIDTH-1:0] Exp_DO,
    output logic                   Zero_SO,
    output logic                   Corr_SO
`ifdef FMAC_NORM_ERRCHK_EN
   ,output logic                   Err_SO
`endif
);

    localparam int unsigned MAX_SHIFT = C_WIDTH - 1;

    // Stage 1 registers (raw inputs)
    logic                   v1;
    logic [C_WIDTH-1:0]     sum1;
    logic [C_LZ_WIDTH-1:0]  lead1;
    logic                   no_one1;
    logic [C_EXP_WIDTH-1:0] exp1;

    logic                   v2;
    logic                   en1, en2;

    logic [31:0]            lead_ext;
    logic                   lead_over;
    logic [C_LZ_WIDTH-1:0]  l_clamp;
    logic [C_WIDTH-1:0]     t_shift;
    logic                   need_corr;
    logic                   is_zero;
    logic [C_EXP_WIDTH-1:0] adj;
    logic [C_WIDTH-1:0]     mant_nxt;
    logic [C_EXP_WIDTH-1:0] exp_nxt;
    logic                   corr_nxt;
`ifdef FMAC_NORM_ERRCHK_EN
    logic                   err_nxt;
`endif

    // A stage may load when it is empty or its contents leave this cycle.
    assign en2      = ~v2 | Ready_SI;
    assign en1      = ~v1 | en2;
    assign Ready_SO = en1;
    assign Valid_SO = v2;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        lead_ext  = 32'(lead1);
        lead_over = lead_ext > MAX_SHIFT;
        l_clamp   = lead_over ? C_LZ_WIDTH'(MAX_SHIFT) : lead1;
        t_shift   = sum1 << l_clamp;
        need_corr = ~t_shift[C_WIDTH-1] & (|t_shift);
        adj       = C_EXP_WIDTH'(l_clamp) + C_EXP_WIDTH'(need_corr);
        is_zero   = no_one1 | ~(|sum1);
        mant_nxt  = need_corr ? (t_shift << 1) : t_shift;
        exp_nxt   = exp1 - adj;
        corr_nxt  = need_corr;
        if (is_zero) begin
            mant_nxt = '0;
            exp_nxt  = '0;
            corr_nxt = 1'b0;
        end
`ifdef FMAC_NORM_ERRCHK_EN
        // Flags an LZA overestimate left uncorrected, or a count beyond the sum width.
        err_nxt = ~is_zero & (~mant_nxt[C_WIDTH-1] | lead_over);
`endif
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            // NOTE: data registers are reset too, because the outputs must read zero after reset.
            v1      <= 1'b0;
            sum1    <= '0;
            lead1   <= '0;
            no_one1 <= 1'b0;
            exp1    <= '0;
            v2      <= 1'b0;
            Mant_DO <= '0;
            Exp_DO  <= '0;
            Zero_SO <= 1'b0;
            Corr_SO <= 1'b0;
`ifdef FMAC_NORM_ERRCHK_EN
            Err_SO  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so both stages advance from the same pre-edge values.
            if (en1) begin
                v1 <= Valid_SI;
                if (Valid_SI) begin
                    sum1    <= Sum_DI;
                    lead1   <= Lead_DI;
                    no_one1 <= No_one_SI;
                    exp1    <= Exp_DI;
                end
            end
            if (en2) begin
                v2 <= v1;
                // Data only moves with a valid beat, so a stalled output holds still.
                if (v1) begin
                    Mant_DO <= mant_nxt;
                    Exp_DO  <= exp_nxt;
                    Zero_SO <= is_zero;
                    Corr_SO <= corr_nxt;
`ifdef FMAC_NORM_ERRCHK_EN
                    Err_SO  <= err_nxt;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fmac_norm_shift.sv
// Scoreboard bench for fmac_norm_shift: directed vectors, backpressure and mid-stream reset.
// Build with FMAC_NORM_ERRCHK_EN defined to also check Err_SO.
module tb_fmac_norm_shift;

    localparam int W  = 74;
    localparam int LW = 7;
    localparam int EW = 10;

    typedef struct {
        logic [W-1:0]  mant;
        logic [EW-1:0] exp;
        logic          zero;
        logic          corr;
        logic          err;
    } exp_t;

    logic          Clk_CI = 1'b0;
    logic          Rst_RBI;
    logic          Valid_SI;
    logic          Ready_SO;
    logic [W-1:0]  Sum_DI;
    logic [LW-1:0] Lead_DI;
    logic          No_one_SI;
    logic [EW-1:0] Exp_DI;
    logic          Valid_SO;
    logic          Ready_SI;
    logic [W-1:0]  Mant_DO;
    logic [EW-1:0] Exp_DO;
    logic          Zero_SO;
    logic          Corr_SO;
`ifdef FMAC_NORM_ERRCHK_EN
    logic          Err_SO;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   send_waits = 0;
    exp_t sb[$];

    fmac_norm_shift #(.C_WIDTH(W), .C_LZ_WIDTH(LW), .C_EXP_WIDTH(EW)) dut (
        .Clk_CI    (Clk_CI),
        .Rst_RBI   (Rst_RBI),
        .Valid_SI  (Valid_SI),
        .Ready_SO  (Ready_SO),
        .Sum_DI    (Sum_DI),
        .Lead_DI   (Lead_DI),
        .No_one_SI (No_one_SI),
        .Exp_DI    (Exp_DI),
        .Valid_SO  (Valid_SO),
        .Ready_SI  (Ready_SI),
        .Mant_DO   (Mant_DO),
        .Exp_DO    (Exp_DO),
        .Zero_SO   (Zero_SO),
        .Corr_SO   (Corr_SO)
`ifdef FMAC_NORM_ERRCHK_EN
       ,.Err_SO    (Err_SO)
`endif
    );

    always #5 Clk_CI = ~Clk_CI;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] m, input logic [EW-1:0] e,
                                input logic z, input logic c, input logic r);
        exp_t t;
        t.mant = m; t.exp = e; t.zero = z; t.corr = c; t.err = r;
        return t;
    endfunction

    // Monitor: outputs are compared to the oldest expected beat every valid cycle,
    // so a stalled beat is re-checked (stability) until it is taken.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk_CI);
            if (Rst_RBI === 1'b1 && Valid_SO === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 128'(Valid_SO), 128'd0);
                end else begin
                    e = sb[0];
                    check("mant", 128'(Mant_DO), 128'(e.mant));
                    check("exp",  128'(Exp_DO),  128'(e.exp));
                    check("zero", 128'(Zero_SO), 128'(e.zero));
                    check("corr", 128'(Corr_SO), 128'(e.corr));
`ifdef FMAC_NORM_ERRCHK_EN
                    check("err",  128'(Err_SO),  128'(e.err));
`endif
                    if (Ready_SI) void'(sb.pop_front());
                end
            end
        end
    end

    // Offer one beat; it is accepted on the first edge where Ready_SO is seen high.
    task automatic send(input logic [W-1:0] s, input logic [LW-1:0] l, input logic n,
                        input logic [EW-1:0] x, input exp_t e);
        int waits = 0;
        Sum_DI = s; Lead_DI = l; No_one_SI = n; Exp_DI = x; Valid_SI = 1'b1;
        @(negedge Clk_CI);
        while (Ready_SO !== 1'b1 && waits < 40) begin
            waits++;
            @(negedge Clk_CI);
        end
        if (Ready_SO !== 1'b1) begin
            check("send_timeout", 128'(Ready_SO), 128'd1);
            Valid_SI = 1'b0;
            return;
        end
        send_waits += waits;
        @(posedge Clk_CI);
        sb.push_back(e);
        #1 Valid_SI = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while (sb.size() != 0 && cyc < 60) begin
            @(negedge Clk_CI);
            cyc++;
        end
        check("drain_empty", 128'(sb.size()), 128'd0);
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 128'(Valid_SO), 128'd0);
        check({tag, "_mant"},  128'(Mant_DO),  128'd0);
        check({tag, "_exp"},   128'(Exp_DO),   128'd0);
        check({tag, "_zero"},  128'(Zero_SO),  128'd0);
        check({tag, "_corr"},  128'(Corr_SO),  128'd0);
`ifdef FMAC_NORM_ERRCHK_EN
        check({tag, "_err"},   128'(Err_SO),   128'd0);
`endif
        check({tag, "_ready"}, 128'(Ready_SO), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] one;
        one = 1;
        Rst_RBI = 1'b0; Valid_SI = 1'b0; Ready_SI = 1'b1;
        Sum_DI = '0; Lead_DI = '0; No_one_SI = 1'b0; Exp_DI = '0;
        repeat (2) @(posedge Clk_CI);
        #1 Rst_RBI = 1'b1;
        check_idle("reset");

        // Exact count, with latency check: valid appears two edges after acceptance.
        send(one << 60, 7'd13, 1'b0, 10'd100, mk(one << 73, 10'd87, 1'b0, 1'b0, 1'b0));
        @(negedge Clk_CI);
        check("latency_c1", 128'(Valid_SO), 128'd0);
        @(negedge Clk_CI);
        check("latency_c2", 128'(Valid_SO), 128'd1);
        drain();

        // Directed vectors streamed back to back with Ready_SI=1: no bubbles allowed.
        send_waits = 0;
        send(one << 60, 7'd12, 1'b0, 10'd100, mk(one << 73, 10'd87,  1'b0, 1'b1, 1'b0));
        send('0,        7'd5,  1'b1, 10'd33,  mk('0,        10'd0,   1'b1, 1'b0, 1'b0));
        send(74'd3,     7'd72, 1'b0, 10'd5,   mk(74'd3 << 72, 10'd957, 1'b0, 1'b0, 1'b0));
        send(one << 10, 7'd3,  1'b1, 10'd50,  mk('0,        10'd0,   1'b1, 1'b0, 1'b0));
        send(one << 60, 7'd11, 1'b0, 10'd100, mk(one << 72, 10'd88,  1'b0, 1'b1, 1'b1));
        send(one,       7'd100,1'b0, 10'd200, mk(one << 73, 10'd127, 1'b0, 1'b0, 1'b1));
        send((one << 73) | 74'd5, 7'd0, 1'b0, 10'd0, mk((one << 73) | 74'd5, 10'd0, 1'b0, 1'b0, 1'b0));
        send(one,       7'd72, 1'b0, 10'd10,  mk(one << 73, 10'd961, 1'b0, 1'b1, 1'b0));
        check("no_bubbles", 128'(send_waits), 128'd0);
        drain();

        // Backpressure: 4 beats, Ready_SI low for edges 2..5.
        fork
            begin
                for (int k = 0; k < 4; k++)
                    send((one << 73) | W'(k), 7'd0, 1'b0, EW'(10 + k),
                         mk((one << 73) | W'(k), EW'(10 + k), 1'b0, 1'b0, 1'b0));
            end
            begin
                @(posedge Clk_CI);
                #1 Ready_SI = 1'b0;
                @(posedge Clk_CI);
                #1 check("bp_ready_low", 128'(Ready_SO), 128'd0);
                repeat (3) @(posedge Clk_CI);
                #1 Ready_SI = 1'b1;
            end
        join
        drain();

        // Reset mid-stream with two beats in flight.
        Ready_SI = 1'b0;
        send(one << 73, 7'd0, 1'b0, 10'd20, mk(one << 73, 10'd20, 1'b0, 1'b0, 1'b0));
        send(one << 73, 7'd0, 1'b0, 10'd21, mk(one << 73, 10'd21, 1'b0, 1'b0, 1'b0));
        Rst_RBI = 1'b0;
        sb.delete();
        @(posedge Clk_CI);
        #1 Rst_RBI = 1'b1;
        check_idle("midreset");
        Ready_SI = 1'b1;
        send(one << 50, 7'd23, 1'b0, 10'd40, mk(one << 73, 10'd17, 1'b0, 1'b0, 1'b0));
        @(negedge Clk_CI);
        check("post_reset_c1", 128'(Valid_SO), 128'd0);
        @(negedge Clk_CI);
        check("post_reset_c2", 128'(Valid_SO), 128'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
